// File: rtl/leak_cal_pkg.sv
// Shared types and helpers for the leakage calibration source.
package leak_cal_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam int EXT_W = 64;

    function automatic int idx_w(input int data_w);
        return (data_w > 1) ? $clog2(data_w) : 1;
    endfunction

    // A programmed period of zero still holds each bit for one clock.
    function automatic logic [EXT_W-1:0] eff_period(input logic [EXT_W-1:0] p);
        return (p == '0) ? EXT_W'(1) : p;
    endfunction

endpackage

// File: rtl/leak_cal_source_prescaler.sv
// Per-bit hold counter; pulses terminal on the last clock of each bit period.
module period_prescaler
    import leak_cal_pkg::*;
#(
    parameter int PERIOD_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] period,
    output logic                terminal
);

    logic [PERIOD_W-1:0] cnt;
    logic [PERIOD_W-1:0] last;

    assign last     = PERIOD_W'(eff_period(EXT_W'(period)) - EXT_W'(1));
    assign terminal = enable && (cnt == last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= terminal ? '0 : cnt + PERIOD_W'(1);
        end
    end

endmodule

// File: rtl/leak_cal_source.sv
// Armed calibration source: serialises a captured pattern onto a load bank,
// one bit per programmable period.
module leak_cal_source
    import leak_cal_pkg::*;
#(
    parameter int DATA_W   = 128,
    parameter int PERIOD_W = 32,
    parameter int LOAD_N   = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      arm,
    input  logic                      abort,
    input  logic [DATA_W-1:0]         pattern,
    input  logic [PERIOD_W-1:0]       period,
    input  logic                      lsb_first,
    input  logic                      repeat_en,
    output logic                      busy,
    output logic                      done,
    output logic [idx_w(DATA_W)-1:0]  bit_idx,
    output logic                      leak_bit,
    output logic [LOAD_N-1:0]         load_out
);

    localparam int IDX_W = idx_w(DATA_W);

    state_t              state;
    logic [DATA_W-1:0]   shadow;
    logic [DATA_W-1:0]   pat_q;
    logic [PERIOD_W-1:0] per_q;
    logic                lsb_q;

    logic                terminal;
    logic                last_bit;
    logic [DATA_W-1:0]   shifted;
    logic                next_bit;
    logic                first_cap;
    logic                first_new;

    period_prescaler #(
        .PERIOD_W (PERIOD_W)
    ) u_presc (
        .clk      (clk),
        .rst      (rst),
        .clear    (abort || (state != SHIFT)),
        .enable   (state == SHIFT),
        .period   (per_q),
        .terminal (terminal)
    );

    // Shadow always shifts toward the end that is emitted next.
    assign last_bit  = (bit_idx == IDX_W'(DATA_W - 1));
    assign shifted   = lsb_q ? (shadow >> 1) : (shadow << 1);
    assign next_bit  = lsb_q ? shadow[1] : shadow[DATA_W-2];
    assign first_cap = lsb_q ? pat_q[0] : pat_q[DATA_W-1];
    assign first_new = lsb_first ? pattern[0] : pattern[DATA_W-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            bit_idx  <= '0;
            leak_bit <= 1'b0;
            shadow   <= '0;
            pat_q    <= '0;
            per_q    <= '0;
            lsb_q    <= 1'b0;
        end else if (abort) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            bit_idx  <= '0;
            leak_bit <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (arm) begin
                        shadow   <= pattern;
                        pat_q    <= pattern;
                        per_q    <= period;
                        lsb_q    <= lsb_first;
                        bit_idx  <= '0;
                        leak_bit <= first_new;
                        busy     <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (terminal) begin
                        if (!last_bit) begin
                            shadow   <= shifted;
                            bit_idx  <= bit_idx + IDX_W'(1);
                            leak_bit <= next_bit;
                        end else if (repeat_en) begin
                            shadow   <= pat_q;
                            bit_idx  <= '0;
                            leak_bit <= first_cap;
                        end else begin
                            state    <= DONE;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            bit_idx  <= '0;
                            leak_bit <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_out <= '0;
        end else begin
            load_out <= {LOAD_N{leak_bit}};
        end
    end

endmodule

// File: tb/tb_leak_cal_source.sv
// Scoreboard bench for leak_cal_source: stimulus queues expected per-cycle
// outputs, a negedge monitor pops and compares them.
module tb_leak_cal_source;

    localparam int DW = 8;
    localparam int PW = 8;
    localparam int LN = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          arm = 1'b0;
    logic          abort = 1'b0;
    logic [DW-1:0] pattern = '0;
    logic [PW-1:0] period = '0;
    logic          lsb_first = 1'b0;
    logic          repeat_en = 1'b0;
    logic          busy;
    logic          done;
    logic [2:0]    bit_idx;
    logic          leak_bit;
    logic [LN-1:0] load_out;

    leak_cal_source #(
        .DATA_W   (DW),
        .PERIOD_W (PW),
        .LOAD_N   (LN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .arm       (arm),
        .abort     (abort),
        .pattern   (pattern),
        .period    (period),
        .lsb_first (lsb_first),
        .repeat_en (repeat_en),
        .busy      (busy),
        .done      (done),
        .bit_idx   (bit_idx),
        .leak_bit  (leak_bit),
        .load_out  (load_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_done;
        int idx;
        bit lb;
    } exp_t;

    exp_t q[$];
    int   compared = 0;
    int   mismatched = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: queue front says what the DUT must show this cycle.
    bit   prev_exp = 1'b0;
    bit   eb;
    bit   ed;
    exp_t me;

    always @(negedge clk) begin
        if (rst) begin
            prev_exp = 1'b0;
        end else begin
            check("load_out", 64'(load_out), 64'({LN{prev_exp}}));
            eb = (q.size() != 0) && !q[0].is_done;
            ed = (q.size() != 0) && q[0].is_done;
            check("busy", 64'(busy), 64'(eb));
            check("done", 64'(done), 64'(ed));
            if (q.size() != 0) begin
                me = q.pop_front();
                if (!me.is_done) begin
                    check("bit_idx", 64'(bit_idx), 64'(me.idx));
                    check("leak_bit", 64'(leak_bit), 64'(me.lb));
                    prev_exp = me.lb;
                end else begin
                    check("leak_bit_done", 64'(leak_bit), 64'(0));
                    prev_exp = 1'b0;
                end
            end else begin
                check("leak_bit_idle", 64'(leak_bit), 64'(0));
                prev_exp = 1'b0;
            end
        end
    end

    // Expected stream: every bit in emission order held eff cycles per pass.
    task automatic push_run(input logic [DW-1:0] pat, input int eff,
                            input bit lsb, input int n, input bit with_done);
        exp_t e;
        for (int c = 0; c < n; c++) begin
            e.is_done = 1'b0;
            e.idx     = (c / eff) % DW;
            e.lb      = lsb ? pat[e.idx] : pat[DW-1-e.idx];
            q.push_back(e);
        end
        if (with_done) begin
            e.is_done = 1'b1;
            e.idx     = 0;
            e.lb      = 1'b0;
            q.push_back(e);
        end
    endtask

    task automatic run(input logic [DW-1:0] pat, input int per, input bit lsb,
                       input int passes, input int abort_at, input int noise_at);
        int eff;
        int total;
        int n;
        int guard;
        eff   = (per == 0) ? 1 : per;
        total = DW * eff * passes;
        n     = (abort_at >= 0 && abort_at < total) ? abort_at + 1 : total;
        pattern   = pat;
        period    = PW'(per);
        lsb_first = lsb;
        repeat_en = (passes > 1);
        arm       = 1'b1;
        tick();
        arm = 1'b0;
        push_run(pat, eff, lsb, n, n == total);
        for (int c = 0; c < n + 2; c++) begin
            pattern   = DW'($urandom);
            period    = PW'($urandom);
            lsb_first = 1'($urandom);
            if (passes > 1 && c == DW * eff * (passes - 1)) repeat_en = 1'b0;
            if (c == noise_at) arm = 1'b1;
            if (c == abort_at) abort = 1'b1;
            tick();
            arm   = 1'b0;
            abort = 1'b0;
        end
        repeat_en = 1'b0;
        guard = 0;
        while (q.size() != 0 && guard < 100) begin
            tick();
            guard++;
        end
        check("drain", 64'(q.size()), 64'(0));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int per;
        int passes;
        int ab;
        int lim;
        int nz;

        #2 rst = 1'b1;
        #1;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_idx", 64'(bit_idx), 64'(0));
        check("rst_leak", 64'(leak_bit), 64'(0));
        check("rst_load", 64'(load_out), 64'(0));
        repeat (3) tick();
        rst = 1'b0;
        repeat (2) tick();

        run(8'b1011_0001, 3, 1'b1, 1, -1, -1);
        run(8'b1011_0001, 0, 1'b0, 1, -1, -1);
        run(8'b1011_0001, 2, 1'b1, 2, -1, -1);
        run(8'b1011_0001, 3, 1'b1, 1, 5, -1);
        run(8'b1011_0001, 1, 1'b0, 1, -1, 4);

        // arm and abort together in IDLE: nothing may start
        pattern = 8'hFF;
        period  = 8'd1;
        arm     = 1'b1;
        abort   = 1'b1;
        tick();
        arm   = 1'b0;
        abort = 1'b0;
        repeat (3) tick();

        // async reset between edges in the middle of a run
        pattern   = 8'h5A;
        period    = 8'd2;
        lsb_first = 1'b1;
        arm       = 1'b1;
        tick();
        arm = 1'b0;
        push_run(8'h5A, 2, 1'b1, DW * 2, 1'b1);
        repeat (7) tick();
        #1 rst = 1'b1;
        #1;
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_idx", 64'(bit_idx), 64'(0));
        check("mid_rst_leak", 64'(leak_bit), 64'(0));
        check("mid_rst_load", 64'(load_out), 64'(0));
        q.delete();
        tick();
        rst = 1'b0;
        tick();
        run(8'h5A, 2, 1'b1, 1, -1, -1);

        for (int r = 0; r < 12; r++) begin
            per    = int'($urandom_range(0, 3));
            passes = int'($urandom_range(1, 2));
            lim    = DW * ((per == 0) ? 1 : per) * passes - 1;
            ab     = ($urandom % 4 == 0) ? int'($urandom_range(0, lim)) : -1;
            if (ab >= 0) lim = ab;
            nz     = ($urandom % 3 == 0) ? int'($urandom_range(0, lim)) : -1;
            run(DW'($urandom), per, 1'($urandom), passes, ab, nz);
        end

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
